// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and parity-mode constants,
// used by both the receiver and the transmitter.
// Latency: n/a (package). Backpressure: n/a.
package uart_pkg;

  // Frame FSM state encodings (3-bit, legacy-compatible constants)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity modes: the mode bit is XORed into the parity check, so an odd-parity
  // frame with a correct parity bit XORs to zero as well.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity error for a frame: dataXor is the XOR of all data bits.
  function automatic logic parityErr(input logic dataXor, input logic parBit,
                                     input logic oddMode);
    return dataXor ^ parBit ^ oddMode;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for one asynchronous level signal.
// Latency: 2 sys_clk. Backpressure: none (free-running).
// Ports: sys_clk, sys_rst_l (async active-low, flops load RESET_VAL),
//        asyncIn (raw input), syncOut (synchronized output).
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_l,
  input  logic asyncIn,
  output logic syncOut
);

  logic metaQ;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      metaQ   <= RESET_VAL;
      syncOut <= RESET_VAL;
    end else begin
      metaQ   <= asyncIn;
      syncOut <= metaQ;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterized UART receiver with one-entry output holding register.
// Latency: rx_validH rises 1 sys_clk after the last stop-bit sample.
// Backpressure: valid/ready; a frame completing while a word is held and not
// popped is dropped and sets sticky overrun_errH (cleared by err_clrH).
// Ports: sys_clk (OVS x baud), sys_rst_l (async active-low), uart_dataH (serial
// line, idle high), rx_dataH/rx_validH/rx_readyH (word out, LSB first bit),
// frame_errH/parity_errH (per-word flags), overrun_errH, err_clrH.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVS        = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_l,
  input  logic              uart_dataH,
  output logic [DATA_W-1:0] rx_dataH,
  output logic              rx_validH,
  input  logic              rx_readyH,
  output logic              frame_errH,
  output logic              parity_errH,
  output logic              overrun_errH,
  input  logic              err_clrH
);

  localparam int CNT_W = $clog2(OVS);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  logic              lineS;
  logic [2:0]        state, nextState;
  logic [CNT_W-1:0]  cellCnt;
  logic [BIT_W-1:0]  bitCnt;
  logic              stopCnt;
  logic [DATA_W-1:0] shiftReg;
  logic              parErrReg;
  logic              frameErrAcc;

  logic halfTick, cellTick, sampling, cntClr, lastStop, frameDone, frameErrNow;

  uart_sync2 #(.RESET_VAL(1'b1)) uSync (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .asyncIn   (uart_dataH),
    .syncOut   (lineS)
  );

  assign halfTick  = (cellCnt == CNT_HALF);
  assign cellTick  = (cellCnt == CNT_LAST);
  assign sampling  = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
  assign lastStop  = (stopCnt == STOP_LAST);
  assign frameDone = (state == ST_STOP) && cellTick && lastStop;
  // The accumulated stop error only counts from the second stop sample on.
  assign frameErrNow = ~lineS | (stopCnt & frameErrAcc);

  // Counter restarts in IDLE, at the start-bit centre, and after each sample,
  // so every later sample lands one full cell after the start-bit centre.
  assign cntClr = (state == ST_IDLE) || ((state == ST_START) && halfTick) ||
                  (sampling && cellTick);

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:   if (!lineS) nextState = ST_START;
      ST_START:  if (halfTick) nextState = lineS ? ST_IDLE : ST_DATA;
      ST_DATA:   if (cellTick && (bitCnt == BIT_LAST))
                   nextState = HAS_PAR ? ST_PARITY : ST_STOP;
      ST_PARITY: if (cellTick) nextState = ST_STOP;
      ST_STOP:   if (cellTick && lastStop) nextState = ST_IDLE;
      default:   nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state   <= ST_IDLE;
      cellCnt <= '0;
    end else begin
      state   <= nextState;
      cellCnt <= cntClr ? '0 : cellCnt + 1'b1;
    end
  end

  // Frame datapath: shift register, bit/stop counters, parity and stop checks
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      bitCnt      <= '0;
      stopCnt     <= 1'b0;
      shiftReg    <= '0;
      parErrReg   <= 1'b0;
      frameErrAcc <= 1'b0;
    end else begin
      if (state == ST_START)
        bitCnt <= '0;
      else if ((state == ST_DATA) && cellTick)
        bitCnt <= bitCnt + 1'b1;

      if ((state == ST_DATA) && cellTick)
        shiftReg <= {lineS, shiftReg[DATA_W-1:1]};

      if ((state == ST_PARITY) && cellTick)
        parErrReg <= parityErr(^shiftReg, lineS, ODD_MODE);

      if (state != ST_STOP)
        stopCnt <= 1'b0;
      else if (cellTick)
        stopCnt <= stopCnt + 1'b1;

      if ((state == ST_STOP) && cellTick)
        frameErrAcc <= frameErrNow;
    end
  end

  // One-entry holding register; a same-cycle pop frees the slot for the new word.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      rx_dataH     <= '0;
      rx_validH    <= 1'b0;
      frame_errH   <= 1'b0;
      parity_errH  <= 1'b0;
      overrun_errH <= 1'b0;
    end else begin
      if (frameDone && (!rx_validH || rx_readyH)) begin
        rx_dataH    <= shiftReg;
        frame_errH  <= frameErrNow;
        parity_errH <= HAS_PAR & parErrReg;
        rx_validH   <= 1'b1;
      end else if (rx_validH && rx_readyH) begin
        rx_validH <= 1'b0;
      end

      // A new overrun beats a simultaneous clear
      if (frameDone && rx_validH && !rx_readyH)
        overrun_errH <= 1'b1;
      else if (err_clrH)
        overrun_errH <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param over three parameter sets:
// 0 = defaults 8N1 OVS16, 1 = 8 bits even parity 2 stop OVS16,
// 2 = 5 bits odd parity 1 stop OVS8.
module tb_uart_rx_param;

  localparam int N = 3;

  typedef struct packed {
    logic [8:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  logic       sysRstL;
  logic [2:0] lineI, readyI, errClr, abortI;
  logic [2:0] vld, fe, pe, ovr;
  logic [7:0] dataA, dataB;
  logic [4:0] dataC;
  logic [8:0] dOut [N];
  int         readyMode [N];
  exp_t       expQ [N][$];
  int         nCmp = 0;
  int         nBad = 0;

  assign dOut[0] = {1'b0, dataA};
  assign dOut[1] = {1'b0, dataB};
  assign dOut[2] = {4'b0, dataC};

  uart_rx_param dutA (
    .sys_clk(sysClk), .sys_rst_l(sysRstL), .uart_dataH(lineI[0]),
    .rx_dataH(dataA), .rx_validH(vld[0]), .rx_readyH(readyI[0]),
    .frame_errH(fe[0]), .parity_errH(pe[0]), .overrun_errH(ovr[0]),
    .err_clrH(errClr[0]));

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dutB (
    .sys_clk(sysClk), .sys_rst_l(sysRstL), .uart_dataH(lineI[1]),
    .rx_dataH(dataB), .rx_validH(vld[1]), .rx_readyH(readyI[1]),
    .frame_errH(fe[1]), .parity_errH(pe[1]), .overrun_errH(ovr[1]),
    .err_clrH(errClr[1]));

  uart_rx_param #(.DATA_W(5), .OVS(8), .PARITY_EN(1), .PARITY_ODD(1)) dutC (
    .sys_clk(sysClk), .sys_rst_l(sysRstL), .uart_dataH(lineI[2]),
    .rx_dataH(dataC), .rx_validH(vld[2]), .rx_readyH(readyI[2]),
    .frame_errH(fe[2]), .parity_errH(pe[2]), .overrun_errH(ovr[2]),
    .err_clrH(errClr[2]));

  function automatic int dwOf(input int i);     return (i == 2) ? 5 : 8;  endfunction
  function automatic int ovsOf(input int i);    return (i == 2) ? 8 : 16; endfunction
  function automatic int parEnOf(input int i);  return (i == 0) ? 0 : 1;  endfunction
  function automatic int parOddOf(input int i); return (i == 2) ? 1 : 0;  endfunction
  function automatic int stopOf(input int i);   return (i == 1) ? 2 : 1;  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s[%0d]: got %0h, required %0h", nm, i, act, req);
    end
  endtask

  // One bit cell on line i; an aborted stream idles the line high instead.
  task automatic bitCell(input int i, input logic b);
    #1;
    lineI[i] = abortI[i] ? 1'b1 : b;
    repeat (ovsOf(i)) @(posedge sysClk);
  endtask

  // Send one frame; the expected word is queued before the first bit goes out.
  task automatic sendFrame(input int i, input logic [8:0] d, input bit badPar,
                           input int badStop, input int gap, input bit push);
    logic [8:0] m, dm;
    logic       parBit;
    exp_t       e;
    int         dw, extra;
    dw = dwOf(i);
    m  = 9'((1 << dw) - 1);
    dm = d & m;
    e.d  = dm;
    e.fe = (badStop != 0);
    e.pe = (parEnOf(i) != 0) && badPar;
    if (push) expQ[i].push_back(e);
    bitCell(i, 1'b0);
    for (int k = 0; k < dw; k++) bitCell(i, dm[k]);
    if (parEnOf(i) != 0) begin
      // Correct bit makes the count of ones even (or odd in odd mode)
      parBit = 1'($countones(dm) % 2) ^ 1'(parOddOf(i)) ^ badPar;
      bitCell(i, parBit);
    end
    for (int s = 1; s <= stopOf(i); s++) bitCell(i, (s != badStop));
    // A low final stop bit needs idle time before the next start edge
    extra = (badStop == stopOf(i)) ? 2 : 0;
    for (int k = 0; k < gap + extra; k++) bitCell(i, 1'b1);
  endtask

  task automatic randFrame(input int i);
    bit badPar;
    int badStop;
    badPar  = (parEnOf(i) != 0) && ($urandom_range(0, 5) == 0);
    badStop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, stopOf(i))) : 0;
    sendFrame(i, 9'($urandom), badPar, badStop, int'($urandom_range(0, 2)), 1'b1);
  endtask

  task automatic drain(input int i);
    int c;
    c = 0;
    while (expQ[i].size() != 0 && c < 3000) begin
      @(posedge sysClk);
      c++;
    end
    chk("drain_pending", i, expQ[i].size(), 0);
  endtask

  always @(posedge sysClk) begin
    #1;
    for (int i = 0; i < N; i++)
      readyI[i] = (readyMode[i] == 2) ? 1'($urandom_range(0, 1)) : (readyMode[i] == 1);
  end

  for (genvar g = 0; g < N; g++) begin : gMon
    exp_t e;
    always @(negedge sysClk) begin
      if (sysRstL && vld[g] && readyI[g]) begin
        nCmp++;
        if (expQ[g].size() == 0) begin
          nBad++;
          $display("FAIL unexpected_word[%0d]: got data %0h, required no word", g, dOut[g]);
        end else begin
          e = expQ[g].pop_front();
          chk("rx_data", g, dOut[g], e.d);
          chk("frame_err", g, fe[g], e.fe);
          chk("parity_err", g, pe[g], e.pe);
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge sysClk);
    $display("FAIL watchdog: run exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    sysRstL = 1'b1;
    lineI = '1; errClr = '0; abortI = '0; readyI = '0;
    for (int i = 0; i < N; i++) readyMode[i] = 1;
    #3 sysRstL = 1'b0;
    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    for (int i = 0; i < N; i++) begin
      chk("rst_valid", i, vld[i], 0);
      chk("rst_data", i, dOut[i], 0);
      chk("rst_frame_err", i, fe[i], 0);
      chk("rst_parity_err", i, pe[i], 0);
      chk("rst_overrun", i, ovr[i], 0);
    end
    sysRstL = 1'b1;
    repeat (3) @(posedge sysClk);

    fork
      begin : streamA
        sendFrame(0, 9'h0A5, 1'b0, 0, 2, 1'b1);
        // False start: 5 ticks low is shorter than half a bit cell
        #1 lineI[0] = 1'b0;
        repeat (5) @(posedge sysClk);
        #1 lineI[0] = 1'b1;
        repeat (40) @(posedge sysClk);
        readyMode[0] = 2;
        repeat (20) randFrame(0);
        drain(0);
        @(negedge sysClk);
        chk("overrun_idle", 0, ovr[0], 0);
        readyMode[0] = 0;
        sendFrame(0, 9'h011, 1'b0, 0, 1, 1'b1);
        sendFrame(0, 9'h022, 1'b0, 0, 1, 1'b0);
        @(negedge sysClk);
        chk("held_valid", 0, vld[0], 1);
        chk("held_data", 0, dOut[0], 9'h011);
        chk("overrun_set", 0, ovr[0], 1);
        readyMode[0] = 1;
        drain(0);
        @(negedge sysClk);
        chk("overrun_sticky", 0, ovr[0], 1);
        @(posedge sysClk);
        #1 errClr[0] = 1'b1;
        @(posedge sysClk);
        #1 errClr[0] = 1'b0;
        @(negedge sysClk);
        chk("overrun_clr", 0, ovr[0], 0);
      end
      begin : streamB
        sendFrame(1, 9'h003, 1'b1, 0, 1, 1'b1);
        sendFrame(1, 9'h05A, 1'b0, 2, 1, 1'b1);
        readyMode[1] = 2;
        repeat (20) randFrame(1);
        drain(1);
        @(negedge sysClk);
        chk("overrun_none", 1, ovr[1], 0);
      end
      begin : streamC
        sendFrame(2, 9'h01F, 1'b0, 0, 0, 1'b1);
        sendFrame(2, 9'h000, 1'b0, 0, 0, 1'b1);
        readyMode[2] = 2;
        repeat (25) randFrame(2);
        drain(2);
        @(negedge sysClk);
        chk("overrun_none", 2, ovr[2], 0);
      end
    join

    // Reset in the middle of a frame on the OVS=8 receiver
    for (int i = 0; i < N; i++) readyMode[i] = 1;
    fork
      sendFrame(2, 9'h000, 1'b0, 0, 2, 1'b0);
      begin
        repeat (28) @(posedge sysClk);
        #1 abortI[2] = 1'b1;
        repeat (10) @(posedge sysClk);
        #1 sysRstL = 1'b0;
        repeat (3) @(posedge sysClk);
        @(negedge sysClk);
        sysRstL = 1'b1;
        @(negedge sysClk);
        chk("post_rst_valid", 2, vld[2], 0);
        chk("post_rst_overrun", 0, ovr[0], 0);
      end
    join
    repeat (120) @(posedge sysClk);
    @(negedge sysClk);
    chk("abort_no_word", 2, vld[2], 0);
    for (int i = 0; i < N; i++) chk("final_pending", i, expQ[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter OVS, default 16, sys_clk ticks per bit cell; even, 8..64.
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 = parity bit follows the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, number of stop bits checked; legal values 1 or 2.
REQ-006 SHALL have port sys_clk  input  1  system clock, OVS x baud rate.
REQ-007 SHALL have port sys_rst_l  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port uart_dataH  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port rx_dataH  output  DATA_W  received word, LSB = first bit received.
REQ-010 SHALL have port rx_validH  output  1  rx_dataH and per-word flags are valid.
REQ-011 SHALL have port rx_readyH  input  1  consumer accepts the word when high with rx_validH.
REQ-012 SHALL have port frame_errH  output  1  held word had a low stop bit; valid with rx_validH.
REQ-013 SHALL have port parity_errH  output  1  held word failed parity; valid with rx_validH; always 0 when PARITY_EN=0.
REQ-014 SHALL have port overrun_errH  output  1  sticky flag: a completed frame was dropped.
REQ-015 SHALL have port err_clrH  input  1  clears overrun_errH on the next clock.

Function
REQ-016 SHALL pass uart_dataH through a two-flop synchronizer before any use; all sampling uses the synchronized value.
REQ-017 SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-018 IDLE: synchronized line low -> START; bit-cell counter cleared.
REQ-019 START: at counter = OVS/2-1, line still low -> DATA with counter cleared; line high -> IDLE (false start, nothing reported).
REQ-020 DATA/PARITY/STOP: sample the line when counter = OVS-1, then clear the counter; this places each sample at the bit-cell centre.
REQ-021 DATA SHALL shift in DATA_W samples, LSB first, then go to PARITY or STOP.
REQ-022 PARITY: parity_err = XOR(data bits, parity bit) XOR PARITY_ODD, one sample taken.
REQ-023 STOP SHALL take STOP_BITS samples; frame_err = any stop sample low.
REQ-024 After the last stop sample, SHALL return to IDLE on the same cycle, so a start edge half a bit later is accepted.
REQ-025 SHALL provide a one-entry output holding register for frame completion.
REQ-026 Completion with rx_validH=0: load data and flags; rx_validH=1 on the next cycle (latency 1 clock after the last stop sample).
REQ-027 Completion with rx_validH=1 and rx_readyH=0: drop the new frame, keep the held word, set overrun_errH.
REQ-028 Completion on the same cycle as a pop (rx_validH & rx_readyH): load the new word, rx_validH stays 1, no overrun.
REQ-029 Pop without completion: rx_validH=0 on the next cycle; rx_dataH and flags hold their values.
REQ-030 A word with frame_err is still delivered with frame_errH=1.
REQ-031 Bit-cell counter width SHALL be clog2(OVS), wrapping only via explicit clear.
REQ-032 err_clrH and a new overrun on the same cycle: the set wins.

Reset
REQ-033 Reset SHALL put the state in IDLE, clear the counters, and force the synchronizer flops to 1.
REQ-034 Reset SHALL clear rx_dataH, rx_validH, frame_errH, parity_errH and overrun_errH to 0.
REQ-035 Reset mid-frame SHALL abort the frame; no word is delivered after release until a new start bit arrives.

Structure
REQ-036 State encodings and parity-mode constants SHALL reside in shared package uart_pkg, reused by the transmitter.
REQ-037 The synchronizer SHALL be sub-module uart_sync2, with parameter RESET_VAL=1.
REQ-038 The FSM next-state logic SHALL be combinational with a default assignment; all outputs registered.

Verification (OVS=16 unless noted)
REQ-039 Defaults, send 0xA5, 8N1, rx_readyH=1 -> rx_dataH=0xA5, rx_validH high 1 cycle, no flags.
REQ-040 Line low 5 ticks then high -> no state change past START, rx_validH stays 0.
REQ-041 PARITY_EN=1, PARITY_ODD=0, send 0x03 with parity bit 1 -> parity_errH=1 with rx_dataH=0x03.
REQ-042 STOP_BITS=2, send 0x5A with second stop bit low -> frame_errH=1, rx_dataH=0x5A.
REQ-043 rx_readyH=0, send 0x11 then 0x22 -> rx_dataH=0x11, overrun_errH=1; pulse err_clrH -> overrun_errH=0.
REQ-044 DATA_W=5, OVS=8, back-to-back frames 0x1F, 0x00 -> both delivered in order; assert sys_rst_l low mid third frame -> no third word.
